// File: rtl/mesi_isc_snoop_cntl.sv
// MESI ISC broadcast snoop controller: pops one broadcast entry, snoops the
// other three CPUs on the cbus, then enables the originator to complete.
//
// state     | meaning
// ST_IDLE   | waiting for a broadcast entry; pops and captures it
// ST_LOAD   | entry captured; validate type and build the pending snoop mask
// ST_SNOOP  | snoop commands driven to every CPU with a pending bit
// ST_ENABLE | EN_WR/EN_RD driven to the originator until it acks
module mesi_isc_snoop_cntl #(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_status_empty_i,
    input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
    input  logic [1:0]                  broad_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
    output logic                        fifo_rd_o,
    input  logic [3:0]                  cbus_ack_array_i,
    output logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
    output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
    output logic [BROAD_ID_WIDTH-1:0]   cbus_id_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR = BROAD_TYPE_WIDTH'(1);
    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD = BROAD_TYPE_WIDTH'(2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SNOOP  = 2'd2,
        ST_ENABLE = 2'd3
    } state_t;

    state_t                        state, state_nxt;
    logic [3:0]                    mask_q, mask_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [BROAD_TYPE_WIDTH-1:0]   type_q, type_d;
    logic [1:0]                    cpu_q, cpu_d;
    logic [BROAD_ID_WIDTH-1:0]     id_q, id_d;
    logic                          pop;
    logic [CBUS_CMD_WIDTH-1:0]     snoop_cmd;
    logic [CBUS_CMD_WIDTH-1:0]     en_cmd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            mask_q <= '0;
            addr_q <= '0;
            type_q <= '0;
            cpu_q  <= '0;
            id_q   <= '0;
        end else begin
            state  <= state_nxt;
            mask_q <= mask_d;
            addr_q <= addr_d;
            type_q <= type_d;
            cpu_q  <= cpu_d;
            id_q   <= id_d;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_d    = mask_q;
        addr_d    = addr_q;
        type_d    = type_q;
        cpu_d     = cpu_q;
        id_d      = id_q;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_status_empty_i) begin
                    pop       = 1'b1;
                    addr_d    = broad_addr_i;
                    type_d    = broad_type_i;
                    cpu_d     = broad_cpu_id_i;
                    id_d      = broad_id_i;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (type_q == TYPE_WR || type_q == TYPE_RD) begin
                    mask_d    = ~(4'b0001 << cpu_q);
                    state_nxt = ST_SNOOP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SNOOP: begin
                // Only acks against a still-pending (non-NOP) field count.
                mask_d = mask_q & ~cbus_ack_array_i;
                if (mask_d == 4'b0000) begin
                    state_nxt = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                if (cbus_ack_array_i[cpu_q]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset gates the pop strobe so a non-empty FIFO cannot be popped while held.
    assign fifo_rd_o = pop & rst;

    assign snoop_cmd = (type_q == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP;
    assign en_cmd    = (type_q == TYPE_WR) ? CMD_EN_WR : CMD_EN_RD;

    always_comb begin
        cbus_cmd_array_o = '0;
        for (int n = 0; n < 4; n++) begin
            if (state == ST_SNOOP && mask_q[n]) begin
                cbus_cmd_array_o[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = snoop_cmd;
            end else if (state == ST_ENABLE && cpu_q == 2'(n)) begin
                cbus_cmd_array_o[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = en_cmd;
            end
        end
    end

    assign cbus_addr_o = addr_q;
    assign cbus_id_o   = id_q;
    assign busy_o      = (state != ST_IDLE);
    assign err_o       = (state == ST_LOAD) && (type_q != TYPE_WR) && (type_q != TYPE_RD);

endmodule

// File: tb/tb_mesi_isc_snoop_cntl.sv
// Directed self-checking bench for mesi_isc_snoop_cntl with a small FIFO model.
module tb_mesi_isc_snoop_cntl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [31:0] broad_addr;
    logic [1:0]  broad_type;
    logic [1:0]  broad_cpu_id;
    logic [6:0]  broad_id;
    logic        fifo_rd;
    logic [3:0]  ack;
    logic [11:0] cmd;
    logic [31:0] cbus_addr;
    logic [6:0]  cbus_id;
    logic        busy;
    logic        err;

    logic [31:0] ent_addr [16];
    logic [1:0]  ent_type [16];
    logic [1:0]  ent_cpu  [16];
    logic [6:0]  ent_id   [16];
    logic [3:0]  wr_ptr = 4'd0;
    logic [3:0]  rd_ptr = 4'd0;
    int          cyc = 0;
    int          pop_cyc [16];
    logic        rd_while_empty = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign broad_addr   = ent_addr[rd_ptr];
    assign broad_type   = ent_type[rd_ptr];
    assign broad_cpu_id = ent_cpu[rd_ptr];
    assign broad_id     = ent_id[rd_ptr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            pop_cyc[rd_ptr] <= cyc;
            rd_ptr <= rd_ptr + 4'd1;
        end
        if (fifo_rd && fifo_empty) rd_while_empty <= 1'b1;
    end

    mesi_isc_snoop_cntl dut (
        .clk                 (clk),
        .rst                 (rst),
        .fifo_status_empty_i (fifo_empty),
        .broad_addr_i        (broad_addr),
        .broad_type_i        (broad_type),
        .broad_cpu_id_i      (broad_cpu_id),
        .broad_id_i          (broad_id),
        .fifo_rd_o           (fifo_rd),
        .cbus_ack_array_i    (ack),
        .cbus_cmd_array_o    (cmd),
        .cbus_addr_o         (cbus_addr),
        .cbus_id_o           (cbus_id),
        .busy_o              (busy),
        .err_o               (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [1:0] t,
                        input logic [1:0] c, input logic [6:0] i);
        ent_addr[wr_ptr] = a;
        ent_type[wr_ptr] = t;
        ent_cpu[wr_ptr]  = c;
        ent_id[wr_ptr]   = i;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({fifo_rd, busy, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got rd/busy/err=%b expected 000", {fifo_rd, busy, err});
        end
        n_checks++;
        if (cmd !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_cmd: got %h expected 000", cmd);
        end
        n_checks++;
        if (cbus_addr !== 32'h0 || cbus_id !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_entry: got addr=%h id=%h expected 0/0", cbus_addr, cbus_id);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_wr();
        push(32'h1000_0040, 2'd1, 2'd2, 7'd5);
        #1;
        n_checks++;
        if (fifo_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_pop: got %b expected 1", fifo_rd);
        end
        tick();
        n_checks++;
        if (fifo_rd !== 1'b0 || busy !== 1'b1 || cmd !== 12'h000) begin
            n_fail++;
            $display("FAIL wr_load: got rd=%b busy=%b cmd=%h expected 0/1/000", fifo_rd, busy, cmd);
        end
        n_checks++;
        if (cbus_addr !== 32'h1000_0040 || cbus_id !== 7'd5) begin
            n_fail++;
            $display("FAIL wr_entry: got addr=%h id=%h expected 10000040/05", cbus_addr, cbus_id);
        end
        tick();
        n_checks++;
        if (cmd !== 12'h209) begin
            n_fail++;
            $display("FAIL wr_snoop: got %h expected 209", cmd);
        end
        ack = 4'b1111;
        tick();
        ack = 4'b0000;
        n_checks++;
        if (cmd !== 12'h0C0) begin
            n_fail++;
            $display("FAIL wr_enable: got %h expected 0c0", cmd);
        end
        tick();
        n_checks++;
        if (cmd !== 12'h0C0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_enable_hold: got cmd=%h busy=%b expected 0c0/1", cmd, busy);
        end
        ack = 4'b0100;
        tick();
        ack = 4'b0000;
        n_checks++;
        if (busy !== 1'b0 || cmd !== 12'h000) begin
            n_fail++;
            $display("FAIL wr_done: got busy=%b cmd=%h expected 0/000", busy, cmd);
        end
    endtask

    task automatic test_staggered_rd();
        push(32'h2000_0080, 2'd2, 2'd0, 7'd9);
        tick();
        tick();
        n_checks++;
        if (cmd !== 12'h490) begin
            n_fail++;
            $display("FAIL rd_snoop: got %h expected 490", cmd);
        end
        tick();
        ack = 4'b1001;
        n_checks++;
        if (cmd !== 12'h490) begin
            n_fail++;
            $display("FAIL rd_wait_ack3: got %h expected 490", cmd);
        end
        tick();
        ack = 4'b0000;
        n_checks++;
        if (cmd !== 12'h090) begin
            n_fail++;
            $display("FAIL rd_after_ack3: got %h expected 090", cmd);
        end
        tick();
        ack = 4'b0011;
        tick();
        ack = 4'b0000;
        n_checks++;
        if (cmd !== 12'h080) begin
            n_fail++;
            $display("FAIL rd_after_ack1: got %h expected 080", cmd);
        end
        tick();
        ack = 4'b0100;
        n_checks++;
        if (cmd !== 12'h080) begin
            n_fail++;
            $display("FAIL rd_wait_ack2: got %h expected 080", cmd);
        end
        tick();
        ack = 4'b0000;
        n_checks++;
        if (cmd !== 12'h004) begin
            n_fail++;
            $display("FAIL rd_enable: got %h expected 004", cmd);
        end
        tick();
        n_checks++;
        if (cmd !== 12'h004) begin
            n_fail++;
            $display("FAIL rd_enable_hold: got %h expected 004", cmd);
        end
        ack = 4'b0001;
        tick();
        ack = 4'b0000;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_illegal();
        push(32'h3000_0000, 2'd3, 2'd1, 7'h11);
        push(32'h4000_0004, 2'd1, 2'd3, 7'h22);
        tick();
        n_checks++;
        if (err !== 1'b1 || cmd !== 12'h000 || fifo_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_load: got err=%b cmd=%h rd=%b expected 1/000/0", err, cmd, fifo_rd);
        end
        tick();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || fifo_rd !== 1'b1 || cmd !== 12'h000) begin
            n_fail++;
            $display("FAIL ill_back_idle: got err=%b busy=%b rd=%b cmd=%h expected 0/0/1/000",
                     err, busy, fifo_rd, cmd);
        end
        tick();
        n_checks++;
        if (err !== 1'b0 || cbus_addr !== 32'h4000_0004 || cbus_id !== 7'h22) begin
            n_fail++;
            $display("FAIL ill_next_load: got err=%b addr=%h id=%h expected 0/40000004/22",
                     err, cbus_addr, cbus_id);
        end
        tick();
        n_checks++;
        if (cmd !== 12'h049) begin
            n_fail++;
            $display("FAIL ill_next_snoop: got %h expected 049", cmd);
        end
        ack = 4'b1111;
        tick();
        n_checks++;
        if (cmd !== 12'h600) begin
            n_fail++;
            $display("FAIL ill_next_enable: got %h expected 600", cmd);
        end
        tick();
        ack = 4'b0000;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_next_done: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] p0;
        logic       done;
        p0   = rd_ptr;
        done = 1'b0;
        ack  = 4'b1111;
        push(32'h0000_0100, 2'd1, 2'd1, 7'd1);
        push(32'h0000_0200, 2'd2, 2'd2, 7'd2);
        push(32'h0000_0300, 2'd1, 2'd0, 7'd3);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rd_ptr == p0 + 4'd3 && busy == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        ack = 4'b0000;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_timeout: got pops=%0d expected 3 within 60 cycles", rd_ptr - p0);
        end
        n_checks++;
        if (pop_cyc[p0 + 4'd1] - pop_cyc[p0] != 4) begin
            n_fail++;
            $display("FAIL b2b_gap1: got %0d expected 4", pop_cyc[p0 + 4'd1] - pop_cyc[p0]);
        end
        n_checks++;
        if (pop_cyc[p0 + 4'd2] - pop_cyc[p0 + 4'd1] != 4) begin
            n_fail++;
            $display("FAIL b2b_gap2: got %0d expected 4", pop_cyc[p0 + 4'd2] - pop_cyc[p0 + 4'd1]);
        end
    endtask

    task automatic test_reset_in_snoop();
        push(32'h5000_0000, 2'd1, 2'd1, 7'h33);
        push(32'h6000_0010, 2'd2, 2'd3, 7'h44);
        tick();
        tick();
        n_checks++;
        if (cmd !== 12'h241) begin
            n_fail++;
            $display("FAIL rs_snoop: got %h expected 241", cmd);
        end
        ack = 4'b0001;
        tick();
        ack = 4'b0000;
        n_checks++;
        if (cmd !== 12'h240) begin
            n_fail++;
            $display("FAIL rs_outstanding: got %h expected 240", cmd);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (cmd !== 12'h000 || {fifo_rd, busy, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL rs_async: got cmd=%h rd/busy/err=%b expected 000/000", cmd, {fifo_rd, busy, err});
        end
        n_checks++;
        if (cbus_addr !== 32'h0 || cbus_id !== 7'h0) begin
            n_fail++;
            $display("FAIL rs_entry: got addr=%h id=%h expected 0/0", cbus_addr, cbus_id);
        end
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (fifo_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_repop: got %b expected 1", fifo_rd);
        end
        tick();
        n_checks++;
        if (cbus_addr !== 32'h6000_0010 || cbus_id !== 7'h44) begin
            n_fail++;
            $display("FAIL rs_next_entry: got addr=%h id=%h expected 60000010/44", cbus_addr, cbus_id);
        end
        tick();
        n_checks++;
        if (cmd !== 12'h092) begin
            n_fail++;
            $display("FAIL rs_next_snoop: got %h expected 092", cmd);
        end
        ack = 4'b1111;
        tick();
        n_checks++;
        if (cmd !== 12'h800) begin
            n_fail++;
            $display("FAIL rs_next_enable: got %h expected 800", cmd);
        end
        tick();
        ack = 4'b0000;
        n_checks++;
        if (busy !== 1'b0 || rd_while_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_done: got busy=%b rd_while_empty=%b expected 0/0", busy, rd_while_empty);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ent_addr[i] = '0;
            ent_type[i] = '0;
            ent_cpu[i]  = '0;
            ent_id[i]   = '0;
            pop_cyc[i]  = 0;
        end
        rst = 1'b0;
        ack = 4'b0000;
        test_reset();
        test_single_wr();
        test_staggered_rd();
        test_illegal();
        test_back_to_back();
        test_reset_in_snoop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mesi_isc_snoop_cntl.md
# mesi_isc_snoop_cntl

Broadcast-side snoop controller for the MESI inter-stage coherency (ISC) unit. It sits directly downstream of the broadcast FIFO, which is filled by the per-CPU bus-request FIFOs. It pops one broadcast entry at a time, issues snoop commands on the coherency bus (cbus) to every CPU except the originator, and collects their acknowledges. It then grants the originator permission to complete its write or read.

## Interface
Parameters:
- CBUS_CMD_WIDTH, 3, width of each per-CPU cbus command field
- ADDR_WIDTH, 32, transaction address width
- BROAD_TYPE_WIDTH, 2, broadcast type width
- BROAD_ID_WIDTH, 7, broadcast transaction tag width

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-low.
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous active-low reset
- fifo_status_empty_i  in  1  broadcast FIFO empty
- broad_addr_i  in  ADDR_WIDTH  head-entry address (first-word-fall-through)
- broad_type_i  in  BROAD_TYPE_WIDTH  head-entry type: 1=WR, 2=RD, 0/3 illegal
- broad_cpu_id_i  in  2  head-entry originating CPU
- broad_id_i  in  BROAD_ID_WIDTH  head-entry tag
- fifo_rd_o  out  1  one-cycle pop strobe to the broadcast FIFO
- cbus_ack_array_i  in  4  per-CPU acknowledge, bit n = CPU n
- cbus_cmd_array_o  out  4*CBUS_CMD_WIDTH  per-CPU command; field n is bits [(n+1)*W-1 : n*W]
- cbus_addr_o  out  ADDR_WIDTH  address of the active transaction
- cbus_id_o  out  BROAD_ID_WIDTH  tag of the active transaction
- busy_o  out  1  a transaction is in progress (any state other than IDLE)
- err_o  out  1  one-cycle pulse when an illegal-type entry is discarded

cbus command encoding: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4. Values 5–7 are never driven.

## Operation
- **FSM states:** IDLE, LOAD, SNOOP, ENABLE.
- **IDLE:**
  - If `fifo_status_empty_i` = 0: assert `fifo_rd_o` for that cycle and capture addr, type, cpu_id and id into entry registers at the same edge. Next state is LOAD.
  - `fifo_rd_o` is never asserted while empty = 1 and never outside IDLE.
- **LOAD:**
  - Type 1 or 2: set pending mask = ~onehot(cpu_id), i.e. the 3 non-originating CPUs. Next state is SNOOP.
  - Type 0 or 3: pulse `err_o`, discard the entry, return to IDLE.
- **SNOOP:**
  - For each CPU whose pending bit is set, drive WR_SNOOP (type WR) or RD_SNOOP (type RD); all other fields are NOP.
  - A CPU's pending bit clears on the edge where its ack is sampled high while its command is non-NOP. Its field becomes NOP from the next cycle.
  - Acks from CPUs whose field is NOP are ignored, including the originator.
  - Acks may arrive in any order or simultaneously.
  - When the mask reaches 0, next state is ENABLE.
- **ENABLE:**
  - Drive EN_WR (WR) or EN_RD (RD) to the originator only.
  - Return to IDLE on the edge where the originator's ack is sampled high.
- **Shared outputs:** `cbus_addr_o` and `cbus_id_o` hold the captured entry from LOAD through ENABLE.
- **Ordering:** strictly one transaction at a time, in FIFO order.

## Timing
- **Reset:** `rst` low asynchronously forces IDLE, clears the mask and entry registers, and drives all outputs to 0 (all commands NOP). A transaction in progress at reset is lost and its FIFO entry is not restored.
- **Outputs are registered.** Snoop commands first appear in the cycle after LOAD.
- **Back-to-back flow:** IDLE is visited for at least one cycle between transactions, so the next pop is no earlier than the cycle after the return to IDLE.
- **Minimum transaction latency**, pop to return to IDLE with every ack arriving in the first cycle its command is driven: 4 cycles (IDLE→LOAD→SNOOP→ENABLE→IDLE).
- **No timeout.** The controller waits indefinitely for acks.
- **Ack timing:** an ack asserted in the same cycle a command first appears is valid. An ack held high continuously consumes only one command per CPU.

## Test plan
- **Single WR from CPU 2.** Empty=0, type=1, cpu_id=2, addr=0x1000_0040, id=5 → `fifo_rd_o` one pulse; fields 0, 1 and 3 = 1 while field 2 = 0; all acks return → field 2 = 3 until ack2 → IDLE, `busy_o`=0.
- **Staggered acks on RD from CPU 0.** ack3 at cycle+1, ack1 at +3, ack2 at +5 → each field drops to 0 the cycle after its own ack; EN_RD (4) appears on field 0 only after ack2.
- **Illegal type.** type=3 → `err_o` pulses for exactly 1 cycle; no cbus command leaves NOP; the next entry is popped afterwards.
- **Back-to-back entries with acks tied high.** 3 entries queued → 3 pops, with at least 4 cycles between pops; `fifo_rd_o` is never high while empty=1.
- **Reset in SNOOP.** Assert `rst` low with 2 acks outstanding → outputs 0 immediately (asynchronously); after release, the controller pops the next FIFO entry normally.
